mux4_arbiter: RTL and testbench

- Round-robin arbiter that shares one mux_4 datapath between four requesters.
- Drives the 2-bit select of a downstream mux_4 (DATA_WIDTH irrelevant here) and a one-hot grant back to requesters.
- A grant is held until the consumer signals transfer completion (iDone), the owner drops its request, or the optional watchdog expires.
- Sits between the MAC operand sources and the shared operand bus.

---
 rtl/mux4_arbiter.sv | 142 ++++++++++++++
 tb/tb_mux4_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter that shares one mux_4 datapath among four requesters.
// Define MUX_ARB_TIMEOUT_EN to build in the grant watchdog and the oTimeout pulse.
module mux4_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] iReq,
    input  logic               iDone,
    output logic [NUM_REQ-1:0] oGnt,
    output logic [1:0]         oSel,
    output logic               oValid,
    output logic               oTimeout
);

    generate
        if (NUM_REQ != 4) begin : g_bad_num_req
            $error("mux4_arbiter supports NUM_REQ == 4 only");
        end
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("mux4_arbiter TIMEOUT_CYCLES must be within 2..255");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [1:0]         r_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    logic [1:0]         r_sel;
    logic               r_valid;

    logic [1:0]         w_idx [NUM_REQ];
    logic [NUM_REQ-1:0] w_rot;
    logic               w_found;
    logic [1:0]         w_win;
    logic               w_owner_req;
    logic               w_expire;
    logic               w_release;

    // Rotate the request vector so slot 0 is the requester just after the last winner.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        assign w_idx[gi] = r_ptr + 2'(gi + 1);
        assign w_rot[gi] = iReq[w_idx[gi]];
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = 2'b00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_win   = w_idx[i];
            end
        end
    end

    assign w_owner_req = iReq[r_sel];

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wdog;
    logic       r_timeout;

    // A completion in the expiry cycle takes precedence over the watchdog.
    assign w_expire = (r_state == BUSY) && (r_wdog == WDOG_LAST) && !iDone;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog    <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (r_state == BUSY && !w_release) begin
                r_wdog <= r_wdog + 8'd1;
            end else begin
                r_wdog <= 8'd0;
            end
        end
    end

    assign oTimeout = r_timeout;
`else
    assign w_expire = 1'b0;
    assign oTimeout = 1'b0;
`endif

    assign w_release = iDone || !w_owner_req || w_expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= 2'd3;
            r_gnt   <= '0;
            r_sel   <= 2'b00;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= BUSY;
                        r_ptr   <= w_win;
                        r_gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
                        r_sel   <= w_win;
                        r_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        if (w_found) begin
                            r_ptr   <= w_win;
                            r_gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
                            r_sel   <= w_win;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= '0;
                            r_sel   <= 2'b00;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_sel   <= 2'b00;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign oGnt   = r_gnt;
    assign oSel   = r_sel;
    assign oValid = r_valid;

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed self-checking bench for mux4_arbiter; the watchdog section runs only
// when MUX_ARB_TIMEOUT_EN is defined.
module tb_mux4_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] iReq;
    logic       iDone;
    logic [3:0] oGnt;
    logic [1:0] oSel;
    logic       oValid;
    logic       oTimeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux4_arbiter #(
        .NUM_REQ       (4),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .iReq    (iReq),
        .iDone   (iDone),
        .oGnt    (oGnt),
        .oSel    (oSel),
        .oValid  (oValid),
        .oTimeout(oTimeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] gnt, input logic [1:0] sel,
                              input logic valid, input logic to);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {oTimeout, oValid, oSel, oGnt};
        exp = {to, valid, sel, gnt};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed to/valid/sel/gnt=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                   tag, obs[7], obs[6], obs[5:4], obs[3:0], exp[7], exp[6], exp[5:4], exp[3:0]);
        end
        $display("[%0t] %s: gnt=%b sel=%0d valid=%b timeout=%b", $time, tag, oGnt, oSel, oValid, oTimeout);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        iReq  = 4'b0000;
        iDone = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        expect_out("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single request, grant then completion to idle
        iReq = 4'b0100;
        tick();
        expect_out("single_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
        iDone = 1'b1;
        iReq  = 4'b0000;
        tick();
        expect_out("single_done_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        iDone = 1'b0;

        // Fairness with all four requesting
        do_reset();
        iReq = 4'b1111;
        tick();
        expect_out("rr_0", 4'b0001, 2'd0, 1'b1, 1'b0);
        iDone = 1'b1;
        tick();
        expect_out("rr_1", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        expect_out("rr_2", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        expect_out("rr_3", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick();
        expect_out("rr_wrap_0", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out("rr_again_1", 4'b0010, 2'd1, 1'b1, 1'b0);
        iDone = 1'b0;
        iReq  = 4'b0000;
        tick();
        expect_out("rr_drop_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Owner drops request without completion; pointer then wraps to requester 0
        do_reset();
        iReq = 4'b0010;
        tick();
        expect_out("drop_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
        iReq = 4'b0000;
        tick();
        expect_out("drop_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        iReq = 4'b0011;
        tick();
        expect_out("drop_wrap_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
        iDone = 1'b1;
        iReq  = 4'b0000;
        tick();
        expect_out("drop_wrap_done", 4'b0000, 2'd0, 1'b0, 1'b0);
        iDone = 1'b0;

        // Sole requester regranted back-to-back after completion
        iReq = 4'b0100;
        tick();
        expect_out("b2b_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
        iDone = 1'b1;
        tick();
        expect_out("b2b_regrant2_a", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        expect_out("b2b_regrant2_b", 4'b0100, 2'd2, 1'b1, 1'b0);
        iDone = 1'b0;
        iReq  = 4'b0000;
        tick();
        expect_out("b2b_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // No preemption, then reset in the middle of a grant
        iReq = 4'b1000;
        tick();
        expect_out("mid_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
        iReq = 4'b1001;
        tick();
        expect_out("no_preempt3", 4'b1000, 2'd3, 1'b1, 1'b0);
        iDone = 1'b1;
        iReq  = 4'b0001;
        tick();
        expect_out("handoff_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
        iDone = 1'b0;
        iReq  = 4'b1000;
        tick();
        expect_out("handoff_to3", 4'b1000, 2'd3, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        expect_out("reset_mid_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        expect_out("post_reset_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);

`ifdef MUX_ARB_TIMEOUT_EN
        // Watchdog forces a handoff after four busy cycles
        do_reset();
        iReq = 4'b0011;
        tick();
        expect_out("wd_busy_c0", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out("wd_busy_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out("wd_busy_c2", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out("wd_busy_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out("wd_expire", 4'b0010, 2'd1, 1'b1, 1'b1);
        tick();
        expect_out("wd_pulse_end", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Completion in the expiry cycle suppresses the timeout pulse
        do_reset();
        iReq = 4'b0011;
        tick();
        expect_out("wd2_busy_c0", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        expect_out("wd2_busy_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
        iDone = 1'b1;
        iReq  = 4'b0010;
        tick();
        expect_out("wd2_done_wins", 4'b0010, 2'd1, 1'b1, 1'b0);
        iDone = 1'b0;
        tick();
        expect_out("wd2_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
